// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with programmable response latency
// Word-organised memory at BASE; one request accepted at a time, response after LATENCY cycles.
module mem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        armed;
  logic [31:0] mem [DEPTH];
  logic [31:0] off;
  logic [IW-1:0] idx;
  logic        bad;
  logic        accept;

  // Unsigned subtraction: addresses below BASE wrap high and fail the range test.
  assign off    = req_addr - BASE;
  assign idx    = off[IW+1:2];
  assign bad    = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || ((off >> 2) >= 32'(DEPTH));
  // armed holds req_ready low until the first edge after reset release.
  assign req_ready = armed && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      armed     <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        rsp_err   <= bad;
        rsp_rdata <= (!bad && !req_wen) ? mem[idx] : 32'd0;
      end
    end
  end

  // Memory contents survive reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && req_wen && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
// Two instances share the request bus: LATENCY=2 for most steps, LATENCY=4 for reset mid-op.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        req_valid, req_valid4;
  logic        req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_ready;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_ready4, rsp_valid4, rsp_err4;
  logic [31:0] rsp_rdata4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with req_ready expected high; returns at the negedge after the handshake.
  task automatic xact(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, output logic [31:0] rdata, output logic err,
                      output int lat);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    chk("valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        seen;

    rst = 1'b0; rst4 = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; req_wen = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_wmask = 4'd0; rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst4_req_ready", 32'(req_ready4), 32'd0);
    rst = 1'b1; rst4 = 1'b1;
    #1;
    chk("release_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("release_ready_high", 32'(req_ready), 32'd1);

    xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_err", 32'(er), 32'd0);
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lat);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_rdata", rd, 32'hDEAD_BEEF);
    chk("rd_err", 32'(er), 32'd0);

    xact(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, rd, er, lat);
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lat);
    chk("mask_rdata", rd, 32'hDE22_BE44);

    xact(1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, rd, er, lat);
    xact(1'b0, 32'h8000_0002, 32'd0, 4'h0, rd, er, lat);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    xact(1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, rd, er, lat);
    chk("below_err", 32'(er), 32'd1);
    chk("below_rdata", rd, 32'd0);
    xact(1'b0, 32'h8000_1000, 32'd0, 4'h0, rd, er, lat);
    chk("past_end_err", 32'(er), 32'd1);
    chk("past_end_rdata", rd, 32'd0);
    xact(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("wr_past_end_err", 32'(er), 32'd1);
    chk("wr_past_end_rdata", rd, 32'd0);
    xact(1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("wr_misalign_err", 32'(er), 32'd1);
    xact(1'b0, 32'h8000_0000, 32'd0, 4'h0, rd, er, lat);
    chk("word0_unchanged", rd, 32'h0123_4567);
    chk("word0_err", 32'(er), 32'd0);

    // Backpressure: read held 5 cycles while a competing write stays asserted.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; rsp_ready = 1'b0;
    @(negedge clk);
    req_wen = 1'b1; req_wdata = 32'd0; req_wmask = 4'hF;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDE22_BE44);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    chk("bp_valid_last", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("bp_valid_done", 32'(rsp_valid), 32'd0);
    chk("bp_ready_done", 32'(req_ready), 32'd1);
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lat);
    chk("bp_ignored_write", rd, 32'hDE22_BE44);

    // Reset mid-transaction on the LATENCY=4 instance.
    chk("l4_ready", 32'(req_ready4), 32'd1);
    req_valid4 = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
    req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("l4_rst_valid", 32'(rsp_valid4), 32'd0);
    chk("l4_rst_ready", 32'(req_ready4), 32'd0);
    @(negedge clk);
    rst4 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid4) seen = 1'b1;
    end
    chk("l4_dropped_rsp", 32'(seen), 32'd0);
    chk("l4_ready_after", 32'(req_ready4), 32'd1);
    req_valid4 = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020;
    @(negedge clk);
    req_valid4 = 1'b0;
    lat = 1;
    while (!rsp_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("l4_latency", 32'(lat), 32'd4);
    chk("l4_committed", rsp_rdata4, 32'hCAFE_F00D);
    chk("l4_err", 32'(rsp_err4), 32'd0);
    @(negedge clk);
    chk("l4_valid_done", 32'(rsp_valid4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
